// File: rtl/wash_pkg.sv
// Shared phase codes, fault codes and monitor-state encoding for the wash status monitor.
package wash_pkg;

  localparam logic [2:0] PH_IDLE     = 3'd0;
  localparam logic [2:0] PH_FILLING  = 3'd1;
  localparam logic [2:0] PH_WASHING  = 3'd2;
  localparam logic [2:0] PH_RINSING  = 3'd3;
  localparam logic [2:0] PH_SPINNING = 3'd4;

  localparam logic [1:0] FC_NONE          = 2'b00;
  localparam logic [1:0] FC_ILLEGAL_CODE  = 2'b01;
  localparam logic [1:0] FC_ILLEGAL_TRANS = 2'b10;
  localparam logic [1:0] FC_TIMEOUT       = 2'b11;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_t;

  function automatic logic is_legal_code(input logic [2:0] code);
    return code <= PH_SPINNING;
  endfunction

  // RINSING->WASHING is the second round of a double wash.
  function automatic logic is_legal_step(input logic [2:0] prev, input logic [2:0] cur);
    logic ok;
    ok = (prev == cur);
    case (prev)
      PH_IDLE:     ok = ok | (cur == PH_FILLING);
      PH_FILLING:  ok = ok | (cur == PH_WASHING);
      PH_WASHING:  ok = ok | (cur == PH_RINSING);
      PH_RINSING:  ok = ok | (cur == PH_WASHING) | (cur == PH_SPINNING);
      PH_SPINNING: ok = ok | (cur == PH_IDLE);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wash_pulse_stretcher.sv
// Rising-edge detector plus down-counter: stretches a qualified edge into a BUZZ_CYCLES-long pulse.
module wash_pulse_stretcher #(
  parameter int BUZZ_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  input  logic enable_i,
  output logic fire_o,
  output logic pulse_o
);

  logic       level_q;
  logic       pulse_q;
  logic [3:0] count_q;

  assign fire_o  = level_i & ~level_q & enable_i;
  assign pulse_o = pulse_q;

  // A fresh edge reloads the counter even if a pulse is still running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= 4'd0;
    end else begin
      level_q <= level_i;
      if (fire_o) begin
        pulse_q <= 1'b1;
        count_q <= 4'(BUZZ_CYCLES - 1);
      end else if (count_q != 4'd0) begin
        count_q <= count_q - 4'd1;
      end else begin
        pulse_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wash_status_monitor.sv
// Washing-machine phase monitor: door lock, end-of-cycle buzzer, wash counter and sticky faults.
// Optional phase timeout is enabled by defining WASH_PHASE_TIMEOUT_EN.
module wash_status_monitor import wash_pkg::*; #(
  parameter logic [31:0] TIMEOUT_COUNT = 32'd64,
  parameter int          BUZZ_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  current_state,
  input  logic        wash_done,
  input  logic        fault_clr,
  output logic        door_lock,
  output logic        buzzer,
  output logic [7:0]  cycle_count,
  output logic [15:0] phase_time,
  output logic        fault,
  output logic [1:0]  fault_code
);

  mon_state_t  mon_q;
  logic [2:0]  prev_state_q;
  logic [15:0] phase_time_q;
  logic [7:0]  cycle_count_q;
  logic        door_lock_q;
  logic        fault_q;
  logic [1:0]  fault_code_q;

  logic        phase_change, code_illegal, trans_illegal, timeout_cause, any_cause;
  logic [1:0]  fault_code_d;
  logic [15:0] pt_inc_d, pt_next_d;
  logic        beep_en, beep_fire;

  always_comb begin
    phase_change  = (current_state != prev_state_q);
    code_illegal  = !is_legal_code(current_state);
    // Once faulted the phase sequence is meaningless, so only code/timeout causes block a clear.
    trans_illegal = (mon_q != MON_FAULT) && !code_illegal &&
                    !is_legal_step(prev_state_q, current_state);
    pt_inc_d      = (phase_time_q == 16'hFFFF) ? phase_time_q : phase_time_q + 16'd1;
    pt_next_d     = phase_change ? 16'd0 : pt_inc_d;
    any_cause     = code_illegal | trans_illegal | timeout_cause;
    fault_code_d  = FC_NONE;
    if (code_illegal)       fault_code_d = FC_ILLEGAL_CODE;
    else if (trans_illegal) fault_code_d = FC_ILLEGAL_TRANS;
    else if (timeout_cause) fault_code_d = FC_TIMEOUT;
    beep_en       = (mon_q != MON_FAULT) && !any_cause;
  end

`ifdef WASH_PHASE_TIMEOUT_EN
  assign timeout_cause = !code_illegal && (current_state != PH_IDLE) && !phase_change &&
                         ({16'd0, pt_inc_d} >= TIMEOUT_COUNT);
`else
  logic unused_timeout_count;
  assign unused_timeout_count = ^TIMEOUT_COUNT;
  assign timeout_cause        = 1'b0;
`endif

  wash_pulse_stretcher #(.BUZZ_CYCLES(BUZZ_CYCLES)) u_buzz (
    .clk      (clk),
    .reset    (reset),
    .level_i  (wash_done),
    .enable_i (beep_en),
    .fire_o   (beep_fire),
    .pulse_o  (buzzer)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_q         <= MON_IDLE;
      prev_state_q  <= PH_IDLE;
      phase_time_q  <= 16'd0;
      cycle_count_q <= 8'd0;
      door_lock_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_code_q  <= FC_NONE;
    end else begin
      prev_state_q <= current_state;
      if (beep_fire && cycle_count_q != 8'hFF)
        cycle_count_q <= cycle_count_q + 8'd1;
      case (mon_q)
        MON_IDLE, MON_RUN: begin
          if (any_cause) begin
            mon_q        <= MON_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= fault_code_d;
            door_lock_q  <= 1'b1;
            phase_time_q <= pt_next_d;
          end else if (mon_q == MON_IDLE) begin
            phase_time_q <= 16'd0;
            if (current_state != PH_IDLE) begin
              mon_q       <= MON_RUN;
              door_lock_q <= 1'b1;
            end
          end else if (prev_state_q == PH_SPINNING && current_state == PH_IDLE) begin
            mon_q        <= MON_IDLE;
            door_lock_q  <= 1'b0;
            phase_time_q <= 16'd0;
          end else begin
            phase_time_q <= pt_next_d;
          end
        end
        default: begin
          if (fault_clr && !any_cause) begin
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            phase_time_q <= 16'd0;
            mon_q        <= (current_state == PH_IDLE) ? MON_IDLE : MON_RUN;
            door_lock_q  <= (current_state != PH_IDLE);
          end else begin
            phase_time_q <= pt_next_d;
          end
        end
      endcase
    end
  end

  assign door_lock   = door_lock_q;
  assign cycle_count = cycle_count_q;
  assign phase_time  = phase_time_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

endmodule

// File: doc/wash_status_monitor.md
WASH_STATUS_MONITOR -- requirements
Module: wash_status_monitor

Interface
REQ-001 The block SHALL have parameter TIMEOUT_COUNT, default 32'd64, meaning the maximum cycles allowed in one non-IDLE phase.
REQ-002 The block SHALL have parameter BUZZ_CYCLES, default 4, meaning the buzzer pulse length in clk cycles (range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port current_state, input, 3 bits: the washing machine controller phase code.
REQ-006 The block SHALL have port wash_done, input, 1 bit: the controller cycle-complete level.
REQ-007 The block SHALL have port fault_clr, input, 1 bit: a one-cycle request to clear a sticky fault.
REQ-008 The block SHALL have port door_lock, output, 1 bit: door solenoid lock.
REQ-009 The block SHALL have port buzzer, output, 1 bit: end-of-cycle beep pulse.
REQ-010 The block SHALL have port cycle_count, output, 8 bits: completed washes, saturating.
REQ-011 The block SHALL have port phase_time, output, 16 bits: cycles spent in the current phase, saturating.
REQ-012 The block SHALL have port fault, output, 1 bit: sticky fault flag.
REQ-013 The block SHALL have port fault_code, output, 2 bits: 00 none, 01 illegal code, 10 illegal transition, 11 timeout.

Function
REQ-014 Phase codes SHALL be IDLE=0, FILLING=1, WASHING=2, RINSING=3, SPINNING=4; codes 5..7 are illegal.
REQ-015 The block SHALL register current_state and wash_done once, and compare each registered state with the previous sample; every output is registered, so a response appears 1 cycle after the input is sampled.
REQ-016 Legal changes SHALL be IDLE->FILLING, FILLING->WASHING, WASHING->RINSING, RINSING->WASHING (second round of a double wash), RINSING->SPINNING and SPINNING->IDLE; holding the same code is always legal.
REQ-017 The monitor FSM SHALL have states MON_IDLE, MON_RUN and MON_FAULT: MON_IDLE->MON_RUN on a legal exit from IDLE, MON_RUN->MON_IDLE on SPINNING->IDLE, and any state->MON_FAULT on a fault.
REQ-018 phase_time SHALL clear to 0 on any phase change, increment by 1 per cycle otherwise, saturate at 16'hFFFF, and read 0 in MON_IDLE.
REQ-019 door_lock SHALL be 1 in MON_RUN and MON_FAULT, and 0 in MON_IDLE.
REQ-020 A rising edge of wash_done in MON_RUN or MON_IDLE SHALL drive buzzer high for exactly BUZZ_CYCLES cycles and increment cycle_count by 1, saturating at 8'hFF.
REQ-021 A new wash_done edge while buzzer is already high SHALL restart the pulse length and still count.
REQ-022 An illegal code SHALL set fault=1 with fault_code=01.
REQ-023 An illegal transition SHALL set fault=1 with fault_code=10.
REQ-024 When several fault causes occur together, the code SHALL be chosen by priority 01 > 10 > 11.
REQ-025 fault and fault_code SHALL hold until fault_clr=1 is sampled while no fault cause is present; a fault cause in the same cycle as fault_clr wins.
REQ-026 On clear, the FSM SHALL go to MON_IDLE if current_state=IDLE, else to MON_RUN with phase_time=0.
REQ-027 A wash_done edge in the same cycle as a fault cause SHALL NOT beep and SHALL NOT count; wash_done edges in MON_FAULT SHALL be ignored.

Reset
REQ-028 While reset=1, door_lock, buzzer, fault SHALL be 0, cycle_count, phase_time SHALL be 0, fault_code SHALL be 00, the FSM SHALL be MON_IDLE, and the previous-sample registers SHALL be IDLE and 0.
REQ-029 Reset asserted mid-cycle SHALL abort any beep and fault immediately, asynchronously to clk.
REQ-030 The first sample after reset SHALL be compared against IDLE.

Configuration
REQ-031 With WASH_PHASE_TIMEOUT_EN defined, phase_time reaching TIMEOUT_COUNT in a non-IDLE phase SHALL set fault=1 with fault_code=11.
REQ-032 Without WASH_PHASE_TIMEOUT_EN, the timeout logic SHALL be absent and fault_code 11 SHALL never occur.

Structure
REQ-033 Package wash_pkg SHALL hold the phase-code constants, the fault-code constants and the monitor-state encoding.
REQ-034 The buzzer pulse SHALL be implemented in sub-module wash_pulse_stretcher (edge-detect plus down-counter, parameter BUZZ_CYCLES).

Verification
REQ-035 The bench SHALL drive reset=1 for 250 ns, then release -> all outputs 0, door_lock=0.
REQ-036 The bench SHALL drive 0->1->2->3->4->0, holding 12/30/12/6 cycles, then wash_done=1 -> door_lock=1 throughout, phase_time peaks 11/29/11/5, buzzer high 4 cycles, cycle_count=1, door_lock=0.
REQ-037 The bench SHALL run a double wash 0->1->2->3->2->3->4->0 -> no fault, cycle_count increments by 1.
REQ-038 The bench SHALL drive 1->3 -> fault=1, fault_code=10, door_lock=1.
REQ-039 The bench SHALL then drive current_state=0 with fault_clr=1 -> fault=0, FSM MON_IDLE, door_lock=0.
REQ-040 The bench SHALL drive current_state=6 in the same cycle as a wash_done edge -> fault_code=01, buzzer=0, cycle_count unchanged.
REQ-041 With WASH_PHASE_TIMEOUT_EN and TIMEOUT_COUNT=20, the bench SHALL hold WASHING for 30 cycles -> fault_code=11 at phase_time=20.
REQ-042 Without WASH_PHASE_TIMEOUT_EN, the same stimulus SHALL give no fault.
REQ-043 The bench SHALL assert reset during SPINNING -> buzzer, door_lock, phase_time=0 immediately.
